mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, the data width.
REQ-003 The module SHALL have parameter MAX_D_BURST, default 4, the maximum number of consecutive D grants while I waits.
REQ-004 One clock and one reset SHALL be used; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock, all state updates on the rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 i_req  in  1  fetch request, held high until i_data_valid.
REQ-008 i_address  in  ADDR_W  fetch address.
REQ-009 i_data_read  out  DATA_W  fetched word.
REQ-010 i_data_valid  out  1  one-cycle fetch completion pulse.
REQ-011 d_req  in  1  data request, held high until d_data_valid.
REQ-012 d_write_enable  in  1  1 = store, 0 = load.
REQ-013 d_address  in  ADDR_W  data address.
REQ-014 d_data_write  in  DATA_W  store data.
REQ-015 d_data_read  out  DATA_W  loaded word.
REQ-016 d_data_valid  out  1  one-cycle load/store completion pulse.
REQ-017 m_req  out  1  shared-port access request.
REQ-018 m_address  out  ADDR_W  shared-port address.
REQ-019 m_data_write  out  DATA_W  shared-port write data.
REQ-020 m_write_enable  out  1  shared-port write strobe.
REQ-021 m_data_read  in  DATA_W  shared-port read data.
REQ-022 m_data_valid  in  1  shared-port completion, for reads and writes.

Function
REQ-023 The FSM SHALL have the states IDLE, I_BUSY, D_BUSY, I_RESP and D_RESP.
REQ-024 IDLE SHALL go to D_BUSY when d_req is high and the starve count is below MAX_D_BURST.
REQ-025 Otherwise IDLE SHALL go to I_BUSY when i_req is high, and SHALL stay in IDLE when no request is high.
REQ-026 On the grant edge the module SHALL latch the granted address, write data and write enable into the m_* registers.
REQ-027 m_req SHALL be high in I_BUSY and D_BUSY only, and m_* outputs SHALL stay stable until m_data_valid.
REQ-028 In x_BUSY with m_data_valid high, the FSM SHALL go to x_RESP and register m_data_read into x_data_read.
REQ-029 In x_BUSY with m_data_valid low, the FSM SHALL stay in x_BUSY with no timeout.
REQ-030 In x_RESP, x_data_valid SHALL be high for exactly that one cycle, then the FSM SHALL go to IDLE.
REQ-031 x_data_read SHALL hold its value until the next completion on that side.
REQ-032 Latency SHALL be: req sampled at edge E, m_req high from E; m_data_valid in cycle k gives x_data_valid in cycle k+1; the minimum is 2 cycles from req to valid.
REQ-033 The starve counter SHALL be 3 bits wide and saturating.
REQ-034 The starve counter SHALL increment on a D grant while i_req is high, and SHALL clear on an I grant or on a D grant while i_req is low.
REQ-035 When d_req and i_req are both high and count equals MAX_D_BURST, I SHALL be granted.
REQ-036 When d_req and i_req are both high and count is below MAX_D_BURST, D SHALL be granted.
REQ-037 m_data_valid SHALL be ignored in IDLE and in the RESP states.
REQ-038 A req dropped mid-transaction SHALL NOT abort the transaction, and the response pulse SHALL still be issued.
REQ-039 For a D store, d_data_read SHALL be updated with m_data_read, whose value is don't-care.
REQ-040 i_data_valid and d_data_valid SHALL never be high in the same cycle.

Reset
REQ-041 While reset_n is low the FSM SHALL be in IDLE and the starve counter SHALL be 0.
REQ-042 While reset_n is low m_req, m_write_enable, i_data_valid and d_data_valid SHALL be 0.
REQ-043 While reset_n is low m_address, m_data_write, i_data_read and d_data_read SHALL be 0.
REQ-044 Reset asserted mid-transaction SHALL abandon the transaction, and no response pulse SHALL be issued after release.
REQ-045 The first grant after reset release SHALL come at the first rising edge with reset_n high and a request present.

Structure
REQ-046 The FSM state enum arb_state_t and the default MAX_D_BURST value SHALL reside in the shared package dlx_pkg.
REQ-047 No sub-module SHALL be used; the FSM, starve counter and request latches SHALL be written inline.

Verification
REQ-048 Single fetch i_address=0x40, with memory returning 0xDEADBEEF one cycle after m_req, SHALL give i_data_valid one pulse with i_data_read=0xDEADBEEF and m_write_enable=0.
REQ-049 A store with d_address=0x100 and d_data_write=0x12345678 SHALL drive m_write_enable=1 and m_address=0x100 until m_data_valid, then d_data_valid one pulse.
REQ-050 Simultaneous i_req and d_req SHALL grant D first; I SHALL be served next after D_RESP.
REQ-051 d_req held continuously with i_req high, MAX_D_BURST=4, SHALL give exactly 4 D completions, then 1 I completion, then D resumes.
REQ-052 m_data_valid held low for 10 cycles in D_BUSY SHALL keep m_address stable; m_data_valid pulsed in IDLE SHALL produce no valid output.
REQ-053 reset_n pulsed low during I_BUSY SHALL drop m_req asynchronously, and no i_data_valid SHALL follow; a new fetch afterwards SHALL complete normally.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared types and defaults for the DLX memory-side blocks.
package dlx_pkg;

  localparam int unsigned MAX_D_BURST_DEFAULT = 4;
  localparam int unsigned STARVE_W            = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_RESP = 3'd3,
    D_RESP = 3'd4
  } arb_state_t;

endpackage : dlx_pkg

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single memory port,
// favouring D but bounding how long a waiting fetch can be starved.
module mem_arbiter
  import dlx_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_D_BURST = MAX_D_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_data_read,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_write_enable,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_data_write,
  output logic [DATA_W-1:0] d_data_read,
  output logic              d_data_valid,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data_write,
  output logic              m_write_enable,
  input  logic [DATA_W-1:0] m_data_read,
  input  logic              m_data_valid
);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve;

  // D wins unless a waiting fetch has already been passed over MAX_D_BURST times;
  // with no fetch pending there is nothing to starve, so D is never blocked.
  logic                d_grant_c;
  logic [STARVE_W-1:0] starve_inc_c;

  assign d_grant_c    = d_req && ((starve < STARVE_W'(MAX_D_BURST)) || !i_req);
  assign starve_inc_c = (starve == '1) ? starve : starve + STARVE_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      starve         <= '0;
      m_req          <= 1'b0;
      m_address      <= '0;
      m_data_write   <= '0;
      m_write_enable <= 1'b0;
      i_data_read    <= '0;
      i_data_valid   <= 1'b0;
      d_data_read    <= '0;
      d_data_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (d_grant_c) begin
            state          <= D_BUSY;
            m_req          <= 1'b1;
            m_address      <= d_address;
            m_data_write   <= d_data_write;
            m_write_enable <= d_write_enable;
            starve         <= i_req ? starve_inc_c : '0;
          end else if (i_req) begin
            state          <= I_BUSY;
            m_req          <= 1'b1;
            m_address      <= i_address;
            m_data_write   <= '0;
            m_write_enable <= 1'b0;
            starve         <= '0;
          end
        end
        I_BUSY: begin
          if (m_data_valid) begin
            state          <= I_RESP;
            m_req          <= 1'b0;
            m_write_enable <= 1'b0;
            i_data_read    <= m_data_read;
            i_data_valid   <= 1'b1;
          end
        end
        D_BUSY: begin
          if (m_data_valid) begin
            state          <= D_RESP;
            m_req          <= 1'b0;
            m_write_enable <= 1'b0;
            d_data_read    <= m_data_read;
            d_data_valid   <= 1'b1;
          end
        end
        I_RESP: begin
          i_data_valid <= 1'b0;
          state        <= IDLE;
        end
        D_RESP: begin
          d_data_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, priority, burst limit,
// stalls, spurious completions and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] i_data_read;
  logic        i_data_valid;
  logic        d_req;
  logic        d_write_enable;
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic [31:0] d_data_read;
  logic        d_data_valid;
  logic        m_req;
  logic [31:0] m_address;
  logic [31:0] m_data_write;
  logic        m_write_enable;
  logic [31:0] m_data_read;
  logic        m_data_valid;

  int n_cmp;
  int n_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req          (i_req),
    .i_address      (i_address),
    .i_data_read    (i_data_read),
    .i_data_valid   (i_data_valid),
    .d_req          (d_req),
    .d_write_enable (d_write_enable),
    .d_address      (d_address),
    .d_data_write   (d_data_write),
    .d_data_read    (d_data_read),
    .d_data_valid   (d_data_valid),
    .m_req          (m_req),
    .m_address      (m_address),
    .m_data_write   (m_data_write),
    .m_write_enable (m_write_enable),
    .m_data_read    (m_data_read),
    .m_data_valid   (m_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: waits for m_req, stalls wait_cyc cycles, completes,
  // and reports which side pulsed valid (1 = I, 2 = D, 0 = none/timeout).
  task automatic mem_cycle(input logic [31:0] rdata, input int unsigned wait_cyc, output int who);
    int t;
    t = 0;
    while (!m_req && t < 20) begin
      cyc();
      t++;
    end
    check("m_req_timeout", 32'(m_req), 32'd1);
    who = 0;
    if (m_req) begin
      repeat (wait_cyc) cyc();
      m_data_read  = rdata;
      m_data_valid = 1'b1;
      cyc();
      m_data_valid = 1'b0;
      check("valid_exclusive", 32'(i_data_valid & d_data_valid), 32'd0);
      if (i_data_valid) who = 1;
      else if (d_data_valid) who = 2;
    end
  endtask

  initial begin
    int who;
    int seq [6];
    int exp_seq [6];
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    i_req = 1'b0;
    i_address = '0;
    d_req = 1'b0;
    d_write_enable = 1'b0;
    d_address = '0;
    d_data_write = '0;
    m_data_read = '0;
    m_data_valid = 1'b0;
    exp_seq = '{2, 2, 2, 2, 1, 2};

    // Reset values
    cyc();
    cyc();
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_we", 32'(m_write_enable), 32'd0);
    check("rst_i_valid", 32'(i_data_valid), 32'd0);
    check("rst_d_valid", 32'(d_data_valid), 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_m_data_write", m_data_write, 32'd0);
    check("rst_i_data_read", i_data_read, 32'd0);
    check("rst_d_data_read", d_data_read, 32'd0);
    reset_n = 1'b1;

    // Single fetch, memory answers in the first m_req cycle
    i_req = 1'b1;
    i_address = 32'h40;
    cyc();
    check("fetch_m_req", 32'(m_req), 32'd1);
    check("fetch_m_address", m_address, 32'h40);
    check("fetch_m_we", 32'(m_write_enable), 32'd0);
    check("fetch_no_early_valid", 32'(i_data_valid), 32'd0);
    m_data_read = 32'hDEADBEEF;
    m_data_valid = 1'b1;
    cyc();
    m_data_valid = 1'b0;
    i_req = 1'b0;
    check("fetch_i_valid", 32'(i_data_valid), 32'd1);
    check("fetch_i_data", i_data_read, 32'hDEADBEEF);
    check("fetch_d_valid", 32'(d_data_valid), 32'd0);
    check("fetch_m_req_drop", 32'(m_req), 32'd0);
    cyc();
    check("fetch_valid_one_cycle", 32'(i_data_valid), 32'd0);

    // Store: write strobe and address held until completion
    d_req = 1'b1;
    d_write_enable = 1'b1;
    d_address = 32'h100;
    d_data_write = 32'h12345678;
    cyc();
    check("store_m_req", 32'(m_req), 32'd1);
    check("store_m_we", 32'(m_write_enable), 32'd1);
    check("store_m_address", m_address, 32'h100);
    check("store_m_data_write", m_data_write, 32'h12345678);
    for (int k = 0; k < 2; k++) begin
      cyc();
      check("store_hold_we", 32'(m_write_enable), 32'd1);
      check("store_hold_addr", m_address, 32'h100);
    end
    m_data_read = 32'h0;
    m_data_valid = 1'b1;
    cyc();
    m_data_valid = 1'b0;
    d_req = 1'b0;
    d_write_enable = 1'b0;
    check("store_d_valid", 32'(d_data_valid), 32'd1);
    check("store_i_valid", 32'(i_data_valid), 32'd0);
    cyc();
    check("store_valid_one_cycle", 32'(d_data_valid), 32'd0);
    check("i_data_read_held", i_data_read, 32'hDEADBEEF);

    // Load stalled 10 cycles, then a spurious completion in IDLE
    d_req = 1'b1;
    d_address = 32'h200;
    cyc();
    for (int k = 0; k < 10; k++) begin
      check("stall_addr", m_address, 32'h200);
      check("stall_m_req", 32'(m_req), 32'd1);
      check("stall_no_valid", 32'(d_data_valid), 32'd0);
      cyc();
    end
    m_data_read = 32'h55AA55AA;
    m_data_valid = 1'b1;
    cyc();
    m_data_valid = 1'b0;
    d_req = 1'b0;
    check("load_d_valid", 32'(d_data_valid), 32'd1);
    check("load_d_data", d_data_read, 32'h55AA55AA);
    cyc();
    cyc();
    m_data_read = 32'h11111111;
    m_data_valid = 1'b1;
    cyc();
    m_data_valid = 1'b0;
    check("idle_spurious_i", 32'(i_data_valid), 32'd0);
    check("idle_spurious_d", 32'(d_data_valid), 32'd0);
    check("idle_spurious_m_req", 32'(m_req), 32'd0);
    check("idle_spurious_d_data", d_data_read, 32'h55AA55AA);
    cyc();
    check("idle_spurious_late_d", 32'(d_data_valid), 32'd0);

    // Simultaneous requests: D first, then I
    i_req = 1'b1;
    i_address = 32'h300;
    d_req = 1'b1;
    d_address = 32'h400;
    mem_cycle(32'hA0A0A0A0, 0, who);
    check("simul_first_is_d", 32'(who), 32'd2);
    d_req = 1'b0;
    mem_cycle(32'hB0B0B0B0, 1, who);
    check("simul_second_is_i", 32'(who), 32'd1);
    check("simul_i_data", i_data_read, 32'hB0B0B0B0);
    i_req = 1'b0;

    // Burst limit: 4 D completions, then I, then D resumes
    i_req = 1'b1;
    i_address = 32'h500;
    d_req = 1'b1;
    d_address = 32'h600;
    for (int k = 0; k < 6; k++) begin
      mem_cycle(32'(k), 0, who);
      seq[k] = who;
      if (who == 1) i_req = 1'b0;
    end
    d_req = 1'b0;
    for (int k = 0; k < 6; k++) check($sformatf("burst_order_%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
    cyc();
    cyc();

    // Reset pulse during I_BUSY abandons the fetch
    i_req = 1'b1;
    i_address = 32'h80;
    cyc();
    check("rstmid_m_req_before", 32'(m_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_m_req_async", 32'(m_req), 32'd0);
    i_req = 1'b0;
    m_data_valid = 1'b1;
    cyc();
    m_data_valid = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rstmid_no_i_valid", 32'(i_data_valid), 32'd0);
      check("rstmid_idle_m_req", 32'(m_req), 32'd0);
    end
    i_req = 1'b1;
    i_address = 32'h44;
    cyc();
    check("post_rst_grant", 32'(m_req), 32'd1);
    check("post_rst_addr", m_address, 32'h44);
    m_data_read = 32'hCAFEF00D;
    m_data_valid = 1'b1;
    cyc();
    m_data_valid = 1'b0;
    i_req = 1'b0;
    check("post_rst_i_valid", 32'(i_data_valid), 32'd1);
    check("post_rst_i_data", i_data_read, 32'hCAFEF00D);
    cyc();
    check("post_rst_valid_drop", 32'(i_data_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_arbiter
